tc_event_timer: RTL

TC_EVENT_TIMER -- requirements
Module: tc_event_timer

---
 rtl/tc_event_timer.sv | 117 +++++++++++
 1 files changed

// File: rtl/tc_event_timer.sv
// rtl/tc_event_timer.sv - event timer counting down-counter borrow pulses into periodic or one-shot ticks
module tc_event_timer (
   input  logic       m_clock,
   input  logic       m_reset,
   input  logic       eu,
   input  logic [3:0] q3_q0,
   input  logic       start,
   input  logic       stop,
   input  logic       one_shot,
   input  logic [3:0] period,
   input  logic       ack,
   output logic       irq,
   output logic       ovf,
   output logic       running,
   output logic [4:0] count,
   output logic [3:0] snap
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t     state;
   state_t     state_next;
   logic [4:0] count_next;
   logic       irq_next;
   logic       ovf_next;
   logic [3:0] snap_next;
   logic [4:0] eff_period;
   logic       tick;
   logic       arm;

   // A period of zero stands for sixteen events
   assign eff_period = (period == 4'd0) ? 5'd16 : {1'b0, period};

   // stop outranks both arming and a coincident eu
   assign arm  = (state == IDLE) && start && !stop;
   assign tick = (state == RUN) && !stop && eu && (count == 5'd1);

   assign running = (state == RUN);

   // State register; reset aborts a run, losing any tick due on that edge
   always_ff @(posedge m_clock or posedge m_reset) begin
      if (m_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (arm) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (tick && one_shot) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      count_next = count;
      irq_next   = irq;
      ovf_next   = ovf;
      snap_next  = snap;

      if (stop) begin
         snap_next = q3_q0;
      end

      if (arm) begin
         count_next = eff_period;
         ovf_next   = 1'b0;
      end else if ((state == RUN) && !stop && eu) begin
         if (count == 5'd1) begin
            count_next = one_shot ? 5'd0 : eff_period;
         end else if (count != 5'd0) begin
            count_next = count - 5'd1;
         end
      end

      // A tick always leaves irq set; an ack in the same cycle is consumed by it
      if (tick) begin
         irq_next = 1'b1;
         if (irq && !ack) begin
            ovf_next = 1'b1;
         end
      end else if (ack) begin
         irq_next = 1'b0;
      end
   end

   // Output registers
   always_ff @(posedge m_clock or posedge m_reset) begin
      if (m_reset) begin
         count <= 5'd0;
         irq   <= 1'b0;
         ovf   <= 1'b0;
         snap  <= 4'd0;
      end else begin
         count <= count_next;
         irq   <= irq_next;
         ovf   <= ovf_next;
         snap  <= snap_next;
      end
   end

endmodule
